bcd_conv_sched: RTL and testbench

- Round-robin scheduler that shares one bin2bcd-style converter (12-bit binary to 4-digit BCD) among NCH requesters.
- Captures one request at a time and drives the converter's bin/en inputs.
- Waits for the converter's rdy pulse, or for a timeout, and returns the BCD result tagged with the requester ID.
- Sits between the display or readout channels and the single shared converter instance.

---
 rtl/bcd_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/bcd_conv_sched.sv | 158 +++++++++++++++
 tb/tb_bcd_conv_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared state encoding, width defaults and helpers for the BCD converter scheduler.
package bcd_sched_pkg;

  localparam int BIN_W_DEF = 12;
  localparam int BCD_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches upward from ptr+1 (mod NCH) for the first request.
// Zero latency; no state, the pointer is owned by the caller.
module rr_arbiter
  import bcd_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IDW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_vld
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NCH);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one bin-to-BCD converter among NCH requesters.
// Response arrives one cycle after conv_rdy (or TIMEOUT cycles after issue); requests wait in IDLE-only capture.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*BIN_W-1:0]    req_bin,
  output logic [NCH-1:0]          req_ready,
  output logic [BIN_W-1:0]        conv_bin,
  output logic                    conv_en,
  input  logic [BCD_W-1:0]        conv_bcd,
  input  logic                    conv_rdy,
  output logic                    resp_valid,
  output logic [clog2(NCH)-1:0]   resp_id,
  output logic [BCD_W-1:0]        resp_bcd,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int IDW = clog2(NCH);
  localparam int CW  = clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
  logic             conv_en_q, conv_en_d;
  logic [NCH-1:0]   req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [BCD_W-1:0] resp_bcd_q, resp_bcd_d;
  logic             resp_err_q, resp_err_d;

  logic [NCH-1:0]   gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_vld;
  logic [BIN_W-1:0] ch_bin [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch_bin[g] = req_bin[g*BIN_W +: BIN_W];
  end

  rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + CW'(1);
    conv_bin_d   = conv_bin_q;
    conv_en_d    = 1'b0;
    req_ready_d  = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_bcd_d   = resp_bcd_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      // Drain whatever the converter was doing before we owned it.
      ST_FLUSH: begin
        cnt_d = cnt_inc;
        if (conv_rdy || cnt_inc == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (gnt_vld) begin
          conv_bin_d  = ch_bin[gnt_idx];
          resp_id_d   = gnt_idx;
          req_ready_d = gnt;
          ptr_d       = gnt_idx;
          conv_en_d   = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      // conv_rdy is checked first so a result landing on the last cycle is not an error.
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (conv_rdy) begin
          resp_bcd_d   = conv_bcd;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else if (cnt_inc == CNT_LAST) begin
          resp_bcd_d   = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_FLUSH;
      ptr_q        <= IDW'(NCH - 1);
      cnt_q        <= '0;
      conv_bin_q   <= '0;
      conv_en_q    <= 1'b0;
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_bcd_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      conv_bin_q   <= conv_bin_d;
      conv_en_q    <= conv_en_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_bcd_q   <= resp_bcd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign conv_bin   = conv_bin_q;
  assign conv_en    = conv_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_bcd   = resp_bcd_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: directed vector table, hand-written corner sequences and a randomized run
// against an arithmetic reference of round-robin order and binary-to-decimal conversion.
module tb_bcd_conv_sched;

  localparam int NCH     = 4;
  localparam int BIN_W   = 12;
  localparam int BCD_W   = 16;
  localparam int TIMEOUT = 128;
  localparam int NUM_RND = 60;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       req_valid;
  logic [NCH*BIN_W-1:0] req_bin;
  logic [NCH-1:0]       req_ready;
  logic [BIN_W-1:0]     conv_bin;
  logic                 conv_en;
  logic [BCD_W-1:0]     conv_bcd;
  logic                 conv_rdy;
  logic                 resp_valid;
  logic [1:0]           resp_id;
  logic [BCD_W-1:0]     resp_bcd;
  logic                 resp_err;
  logic                 busy;

  logic                 man_rdy;
  logic                 model_rdy;
  logic [BCD_W-1:0]     model_bcd;
  int                   m_cd;
  int                   m_lat;
  bit                   m_mute;

  int n_tests;
  int n_fail;

  typedef struct {
    int          ch;
    logic [11:0] bin;
    int          lat;
    bit          mute;
    logic [15:0] exp_bcd;
    bit          exp_err;
    int          exp_off;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] bcd;
    bit          err;
  } resp_t;

  vec_t  vecs [7];
  resp_t expq [$];
  resp_t er;

  int          cont_id  [5];
  logic [15:0] cont_bcd [5];
  int          gi, ri, seen_resp, seen_rdy, idle_at, issued, last, eg, cyc;
  bit          has [NCH];
  logic [11:0] val [NCH];
  logic [3:0]  prev_vld;
  bit          mute, done, got;

  assign conv_rdy = man_rdy | model_rdy;
  assign conv_bcd = model_bcd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_sched #(
    .NCH     (NCH),
    .BIN_W   (BIN_W),
    .BCD_W   (BCD_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_bin    (req_bin),
    .req_ready  (req_ready),
    .conv_bin   (conv_bin),
    .conv_en    (conv_en),
    .conv_bcd   (conv_bcd),
    .conv_rdy   (conv_rdy),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_bcd   (resp_bcd),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  function automatic logic [15:0] ref_bcd(input logic [11:0] v);
    int x;
    x = int'(v);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  function automatic int ref_grant(input logic [3:0] vld, input int from);
    for (int k = 1; k <= NCH; k++) begin
      if (vld[(from + k) % NCH]) return (from + k) % NCH;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Converter stand-in: answers m_lat cycles after it sees conv_en, or never when muted.
  initial begin
    model_rdy = 1'b0;
    model_bcd = '0;
    m_cd      = 0;
    forever begin
      @(posedge clk);
      #2;
      model_rdy = 1'b0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) model_rdy = 1'b1;
      end
      if (conv_en === 1'b1) begin
        model_bcd = ref_bcd(conv_bin);
        m_cd      = m_mute ? 0 : m_lat;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},       32'(busy), 32'd1);
    check({tag, "_req_ready"},  32'(req_ready), 32'd0);
    check({tag, "_conv_en"},    32'(conv_en), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"},   32'(resp_err), 32'd0);
    check({tag, "_conv_bin"},   32'(conv_bin), 32'd0);
    check({tag, "_resp_bcd"},   32'(resp_bcd), 32'd0);
    check({tag, "_resp_id"},    32'(resp_id), 32'd0);
  endtask

  task automatic run_txn(input int ch, input logic [11:0] bin, input int lat, input bit mt,
                         input bit rdy_in_issue, input logic [15:0] exp_bcd, input bit exp_err,
                         input int exp_off, input string tag);
    int  k;
    bit  ok;
    req_bin[ch*BIN_W +: BIN_W] = bin;
    req_valid                  = '0;
    req_valid[ch]              = 1'b1;
    m_lat                      = lat;
    m_mute                     = mt;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (req_ready != '0) ok = 1'b1;
    end
    check({tag, "_granted"},  32'(ok), 32'd1);
    check({tag, "_ready"},    32'(req_ready), 32'd1 << ch);
    check({tag, "_conv_en"},  32'(conv_en), 32'd1);
    check({tag, "_conv_bin"}, 32'(conv_bin), 32'(bin));
    req_valid = '0;
    if (rdy_in_issue) man_rdy = 1'b1;
    ok = 1'b0;
    k  = 0;
    for (int i = 1; i <= TIMEOUT + 20 && !ok; i++) begin
      tick();
      man_rdy = 1'b0;
      if (i == 1) check({tag, "_conv_en_one_cycle"}, 32'(conv_en), 32'd0);
      if (resp_valid) begin
        ok = 1'b1;
        k  = i;
      end
    end
    check({tag, "_resp_seen"}, 32'(ok), 32'd1);
    check({tag, "_latency"},   32'(k), 32'(exp_off));
    check({tag, "_resp_id"},   32'(resp_id), 32'(ch));
    check({tag, "_resp_bcd"},  32'(resp_bcd), 32'(exp_bcd));
    check({tag, "_resp_err"},  32'(resp_err), 32'(exp_err));
    tick();
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_bcd_hold"},   32'(resp_bcd), 32'(exp_bcd));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_bin   = '0;
    man_rdy   = 1'b0;
    m_lat     = 63;
    m_mute    = 1'b0;

    vecs[0] = '{2, 12'd1234, 63,  1'b0, 16'h1234, 1'b0, 64};
    vecs[1] = '{0, 12'd0,    5,   1'b0, 16'h0000, 1'b0, 6};
    vecs[2] = '{3, 12'd4095, 1,   1'b0, 16'h4095, 1'b0, 2};
    vecs[3] = '{1, 12'd999,  127, 1'b0, 16'h0999, 1'b0, TIMEOUT};
    vecs[4] = '{1, 12'd77,   128, 1'b0, 16'h0000, 1'b1, TIMEOUT};
    vecs[5] = '{0, 12'd77,   1,   1'b1, 16'h0000, 1'b1, TIMEOUT};
    vecs[6] = '{3, 12'd100,  63,  1'b0, 16'h0100, 1'b0, 64};

    cont_id  = '{0, 1, 2, 3, 0};
    cont_bcd = '{16'h0000, 16'h0009, 16'h4095, 16'h0100, 16'h0000};

    // Reset values, then FLUSH held until the converter reports done.
    repeat (3) tick();
    check_reset_vals("rst");
    reset     = 1'b1;
    seen_resp = 0;
    done      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b1) done = 1'b0;
      if (resp_valid) seen_resp++;
    end
    check("flush_hold_busy", 32'(done), 32'd1);
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    if (resp_valid) seen_resp++;
    check("flush_exit_idle", 32'(busy), 32'd0);
    tick();
    if (resp_valid) seen_resp++;
    check("flush_no_resp", 32'(seen_resp), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].ch, vecs[v].bin, vecs[v].lat, vecs[v].mute, 1'b0,
              vecs[v].exp_bcd, vecs[v].exp_err, vecs[v].exp_off, $sformatf("vec%0d", v));
    end

    // conv_rdy pulses in IDLE and ISSUE must not produce or shorten a response.
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    check("ign_idle_stays", 32'(busy), 32'd0);
    check("ign_idle_no_resp", 32'(resp_valid), 32'd0);
    run_txn(3, 12'd55, 40, 1'b0, 1'b1, 16'h0055, 1'b0, 41, "ign");

    // All channels requesting continuously.
    req_bin   = {12'd100, 12'd4095, 12'd9, 12'd0};
    req_valid = 4'hF;
    m_lat     = 5;
    m_mute    = 1'b0;
    gi        = 0;
    ri        = 0;
    for (int c = 0; c < 400 && ri < 5; c++) begin
      tick();
      if (req_ready != '0) begin
        if (gi < 5) check($sformatf("cont_grant%0d", gi), 32'(req_ready), 32'd1 << cont_id[gi]);
        gi++;
      end
      if (resp_valid) begin
        check($sformatf("cont_id%0d", ri),  32'(resp_id), 32'(cont_id[ri]));
        check($sformatf("cont_bcd%0d", ri), 32'(resp_bcd), 32'(cont_bcd[ri]));
        check($sformatf("cont_err%0d", ri), 32'(resp_err), 32'd0);
        ri++;
      end
    end
    req_valid = '0;
    check("cont_resp_count", 32'(ri), 32'd5);
    repeat (3) tick();

    // Reset 20 cycles into WAIT abandons the job.
    m_lat = 63;
    req_bin[2*BIN_W +: BIN_W] = 12'd321;
    req_valid = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (req_ready != '0) got = 1'b1;
    end
    check("abort_granted", 32'(got), 32'd1);
    req_valid = '0;
    repeat (20) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("abort");
    reset     = 1'b1;
    seen_resp = 0;
    seen_rdy  = 0;
    idle_at   = -1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (resp_valid) seen_resp++;
      if (req_ready != '0) seen_rdy++;
      if (!busy && idle_at < 0) idle_at = c;
    end
    check("abort_no_resp", 32'(seen_resp), 32'd0);
    check("abort_no_ready", 32'(seen_rdy), 32'd0);
    check("abort_reaches_idle", 32'(idle_at >= 0), 32'd1);

    // Randomized traffic; pointer is back at NCH-1 after the reset above.
    issued   = 0;
    last     = NCH - 1;
    prev_vld = '0;
    expq.delete();
    for (int c = 0; c < NCH; c++) begin
      has[c] = 1'b0;
      val[c] = '0;
    end
    done = 1'b0;
    for (cyc = 0; cyc < 30000 && !done; cyc++) begin
      tick();
      if (req_ready != '0) begin
        eg = ref_grant(prev_vld, last);
        check("rnd_grant", 32'(req_ready), (eg < 0) ? 32'd0 : (32'd1 << eg));
        if (eg >= 0) begin
          check("rnd_conv_bin", 32'(conv_bin), 32'(val[eg]));
          mute   = ($urandom_range(0, 7) == 0);
          m_mute = mute;
          m_lat  = $urandom_range(1, 80);
          expq.push_back('{eg, mute ? 16'h0000 : ref_bcd(val[eg]), mute});
          has[eg] = 1'b0;
          last    = eg;
        end
      end
      if (resp_valid) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_resp", 32'd1, 32'd0);
        end else begin
          er = expq.pop_front();
          check("rnd_resp_id",  32'(resp_id), 32'(er.id));
          check("rnd_resp_bcd", 32'(resp_bcd), 32'(er.bcd));
          check("rnd_resp_err", 32'(resp_err), 32'(er.err));
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (!has[c] && issued < NUM_RND && $urandom_range(0, 5) == 0) begin
          has[c] = 1'b1;
          val[c] = 12'($urandom_range(0, 4095));
          issued++;
        end
        req_valid[c]               = has[c];
        req_bin[c*BIN_W +: BIN_W]  = val[c];
      end
      prev_vld = req_valid;
      done = (issued >= NUM_RND) && (expq.size() == 0) && (req_valid == '0);
    end
    check("rnd_completed", 32'(done), 32'd1);
    m_mute = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
